// File: rtl/phase_pipeline.sv
// phase_pipeline: clocked two-phase bundled-data elastic pipeline with occupancy, full/empty and freeze
module phase_pipeline #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  in_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  in_ack,
    output logic                  out_req,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  out_ack,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  full,
    output logic                  empty
);
    logic [DEPTH-1:0]      a_q, a_d, req_up, ack_dn, fire, full_d;
    logic [DATA_WIDTH-1:0] d_q [DEPTH];
    logic [DATA_WIDTH-1:0] d_d [DEPTH];
    logic [CNT_W-1:0]      occ_q, occ_d;

    assign req_up = {a_q[DEPTH-2:0], in_req};
    assign ack_dn = {out_ack, a_q[DEPTH-1:1]};
    assign fire   = {DEPTH{!freeze}} & (req_up ^ a_q) & ~(a_q ^ ack_dn);

    // firing stages copy upstream phase and data; occupancy counts stages full after this edge
    always_comb begin
        a_d    = (a_q & ~fire) | (req_up & fire);
        full_d = a_d ^ {out_ack, a_d[DEPTH-1:1]};
        d_d[0] = fire[0] ? data_in : d_q[0];
        for (int i = 1; i < DEPTH; i++)
            d_d[i] = fire[i] ? d_q[i-1] : d_q[i];
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_d = occ_d + CNT_W'(full_d[i]);
    end

    // stage registers; reset clears every token and dominates freeze
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                d_q[i] <= '0;
        end else begin
            a_q   <= a_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++)
                d_q[i] <= d_d[i];
        end
    end

    assign in_ack    = a_q[0];
    assign out_req   = a_q[DEPTH-1];
    assign data_out  = d_q[DEPTH-1];
    assign occupancy = occ_q;
    assign full      = occ_q == CNT_W'(DEPTH);
    assign empty     = occ_q == '0;
endmodule
